// File: rtl/asrm_int_conditioner_pkg.sv
// Shared definitions for the external interrupt conditioner.
//   INT_LINES      : number of conditioned interrupt lines
//   ACK_ID_W       : width of the acknowledge index
//   int_mode_e     : per-line capture mode (level pass-through / rising-edge)
package asrm_int_conditioner_pkg;

    localparam int INT_LINES = 4;
    localparam int ACK_ID_W  = $clog2(INT_LINES);

    typedef enum logic {
        INT_MODE_LEVEL = 1'b0,
        INT_MODE_EDGE  = 1'b1
    } int_mode_e;

endpackage

// File: rtl/asrm_int_line.sv
// One conditioned interrupt line: synchroniser, debounce filter, rise detect,
// sticky pending and overflow flags.
//   clk, reset : clock, synchronous active-high reset
//   irq_raw    : asynchronous raw line
//   edge_mode  : 1 = rising-edge capture, 0 = level pass-through
//   ack_hit    : controller acknowledged this line (clears pending only)
//   clear      : software clear of pending and overflow
//   ext_int    : registered request towards the interrupt controller
//   overflow   : registered sticky flag, rise seen while already pending
module asrm_int_line
    import asrm_int_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic ack_hit,
    input  logic clear,
    output logic ext_int,
    output logic overflow
);

    localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   f_q, f_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   ext_int_q, ext_int_d;
    logic                   s;
    logic                   rise;
    logic                   is_edge;

    assign s       = sync_q[SYNC_STAGES-1];
    assign is_edge = (edge_mode == INT_MODE_EDGE);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw};

        // Counter tracks consecutive cycles the synchronised value disagrees
        // with the filtered one; any agreement restarts it.
        f_d   = f_q;
        cnt_d = '0;
        rise  = 1'b0;
        if (s != f_q) begin
            if (cnt_q == CNT_LAST) begin
                f_d  = s;
                rise = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A rise beats any simultaneous clear of pending; overflow is only
        // raised when the pending flag survives this edge, and clear wins.
        if (!is_edge) begin
            pending_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            pending_d  = rise | (pending_q & ~ack_hit & ~clear);
            overflow_d = ~clear & (overflow_q | (rise & pending_q & ~ack_hit));
        end

        // Output chosen from next-state values so the registered request
        // appears at the same edge the filter or pending flag updates.
        ext_int_d = is_edge ? pending_d : f_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            f_q        <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            ext_int_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            f_q        <= f_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ext_int_q  <= ext_int_d;
        end
    end

    assign ext_int  = ext_int_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/asrm_int_conditioner.sv
// Conditions the external interrupt lines feeding the interrupt controller.
//   clk, reset : clock, synchronous active-high reset
//   irq_raw    : asynchronous raw interrupt lines
//   edge_mode  : per-line capture mode (1 = edge, 0 = level)
//   ack,ack_id : controller acknowledge pulse and the interrupt it entered
//   clear      : per-line software clear of pending and overflow
//   ext_int    : conditioned requests to the controller
//   overflow   : per-line sticky overflow flags
module asrm_int_conditioner
    import asrm_int_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INT_LINES-1:0] irq_raw,
    input  logic [INT_LINES-1:0] edge_mode,
    input  logic                 ack,
    input  logic [ACK_ID_W-1:0]  ack_id,
    input  logic [INT_LINES-1:0] clear,
    output logic [INT_LINES-1:0] ext_int,
    output logic [INT_LINES-1:0] overflow
);

    logic [INT_LINES-1:0] ack_hit;

    for (genvar gi = 0; gi < INT_LINES; gi++) begin : g_line
        assign ack_hit[gi] = ack && (ack_id == ACK_ID_W'(gi));

        asrm_int_line #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_line (
            .clk       (clk),
            .reset     (reset),
            .irq_raw   (irq_raw[gi]),
            .edge_mode (edge_mode[gi]),
            .ack_hit   (ack_hit[gi]),
            .clear     (clear[gi]),
            .ext_int   (ext_int[gi]),
            .overflow  (overflow[gi])
        );
    end

endmodule

// File: tb/tb_asrm_int_conditioner.sv
module tb_asrm_int_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_raw, edge_mode, clear;
    logic       ack;
    logic [1:0] ack_id;
    logic [3:0] ext_a, ovf_a, ext_b, ovf_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Default configuration.
    asrm_int_conditioner u_dut_a (
        .clk(clk), .reset(reset), .irq_raw(irq_raw), .edge_mode(edge_mode),
        .ack(ack), .ack_id(ack_id), .clear(clear),
        .ext_int(ext_a), .overflow(ovf_a)
    );

    // Debounce of 4, same stimulus.
    asrm_int_conditioner #(.SYNC_STAGES(2), .DEBOUNCE(4)) u_dut_b (
        .clk(clk), .reset(reset), .irq_raw(irq_raw), .edge_mode(edge_mode),
        .ack(ack), .ack_id(ack_id), .clear(clear),
        .ext_int(ext_b), .overflow(ovf_b)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // h[i][j] holds irq_raw[i] as sampled j+1 edges ago. The synchronised
    // value seen at an edge is the raw value sampled SYNC_STAGES edges
    // earlier; the filter flips once the last DEBOUNCE synchronised samples
    // all disagree with it.
    logic [3:0][7:0] h;
    logic [1:0][3:0] mf, mp, mo, e_ext, e_ovf;
    logic            model_ok = 1'b0;

    always @(posedge clk) begin : model
        logic [1:0][3:0] nf, np, no;
        int   d;
        logic upd, rise, hit;
        if (reset) begin
            mf <= '0; mp <= '0; mo <= '0; e_ext <= '0; e_ovf <= '0; h <= '0;
            model_ok <= 1'b1;
        end else begin
            nf = mf; np = mp; no = mo;
            for (int u = 0; u < 2; u++) begin
                d = (u == 0) ? 1 : 4;
                for (int i = 0; i < 4; i++) begin
                    upd = 1'b1;
                    for (int m = 0; m < d; m++)
                        if (h[i][1+m] == mf[u][i]) upd = 1'b0;
                    rise = upd && !mf[u][i];
                    if (upd) nf[u][i] = !mf[u][i];
                    hit = ack && (ack_id == 2'(i));
                    if (!edge_mode[i]) begin
                        np[u][i] = 1'b0;
                        no[u][i] = 1'b0;
                    end else begin
                        np[u][i] = rise || (mp[u][i] && !hit && !clear[i]);
                        no[u][i] = !clear[i] && (mo[u][i] || (rise && mp[u][i] && !hit));
                    end
                end
            end
            mf <= nf; mp <= np; mo <= no;
            for (int u = 0; u < 2; u++)
                for (int i = 0; i < 4; i++)
                    e_ext[u][i] <= edge_mode[i] ? np[u][i] : nf[u][i];
            e_ovf <= no;
            for (int i = 0; i < 4; i++) h[i] <= {h[i][6:0], irq_raw[i]};
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_ext_d1", ext_a, e_ext[0]);
            chk("model_ovf_d1", ovf_a, e_ovf[0]);
            chk("model_ext_d4", ext_b, e_ext[1]);
            chk("model_ovf_d4", ovf_b, e_ovf[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_raw = '0; ack = 1'b0; ack_id = '0; clear = '0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] irq;
        logic       ack;
        logic [1:0] id;
        logic [3:0] clr;
        logic [3:0] ext;
        logic [3:0] ovf;
    } vec_t;

    vec_t tv[18];

    initial begin
        // Default DUT, edge_mode=0001: line 0 edge capture, line 2 level.
        // Row n: inputs before edge n, outputs expected after edge n.
        tv[0]  = '{4'b0101, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[1]  = '{4'b0101, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[2]  = '{4'b0101, 1'b0, 2'd0, 4'b0000, 4'b0101, 4'b0000};
        tv[3]  = '{4'b0101, 1'b0, 2'd0, 4'b0000, 4'b0101, 4'b0000};
        tv[4]  = '{4'b0101, 1'b1, 2'd2, 4'b0000, 4'b0101, 4'b0000};
        tv[5]  = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0101, 4'b0000};
        tv[6]  = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0101, 4'b0000};
        tv[7]  = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0000};
        tv[8]  = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0000};
        tv[9]  = '{4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[10] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[11] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[12] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[13] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[14] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};
        tv[15] = '{4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0000};
        tv[16] = '{4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000, 4'b0000};
        tv[17] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000};

        edge_mode = 4'b0000;
        do_reset();
        reset = 1'b1;
        cyc();
        chk("reset_ext_d1", ext_a, 4'b0000);
        chk("reset_ovf_d1", ovf_a, 4'b0000);
        chk("reset_ext_d4", ext_b, 4'b0000);
        chk("reset_ovf_d4", ovf_b, 4'b0000);

        // ---- table: edge capture, level pass-through, ack/clear ----
        do_reset();
        edge_mode = 4'b0001;
        for (int n = 0; n < 18; n++) begin
            irq_raw = tv[n].irq; ack = tv[n].ack; ack_id = tv[n].id; clear = tv[n].clr;
            cyc();
            chk($sformatf("tv%0d_ext", n), ext_a, tv[n].ext);
            chk($sformatf("tv%0d_ovf", n), ovf_a, tv[n].ovf);
        end
        ack = 1'b0; clear = '0;

        // ---- debounce of 4 on line 1 ----
        do_reset();
        edge_mode = 4'b0010;
        for (int n = 1; n <= 11; n++) begin
            irq_raw = (n <= 3) ? 4'b0010 : 4'b0000;
            cyc();
            chk("db_short_pulse", ext_b, 4'b0000);
        end
        for (int n = 1; n <= 14; n++) begin
            irq_raw = (n <= 4 || n >= 7) ? 4'b0010 : 4'b0000;
            cyc();
            if (n == 5) chk("db_before_edge6", ext_b, 4'b0000);
            if (n == 6) chk("db_at_edge6", ext_b, 4'b0010);
        end
        chk("db_gap_ext", ext_b, 4'b0010);
        chk("db_gap_ovf", ovf_b, 4'b0000);

        // ---- overflow on line 3 (default DUT) ----
        do_reset();
        edge_mode = 4'b1000;
        for (int n = 1; n <= 8; n++) begin
            irq_raw = (n <= 2 || n == 5 || n == 6) ? 4'b1000 : 4'b0000;
            cyc();
        end
        chk("ovf_set_ext", ext_a, 4'b1000);
        chk("ovf_set_ovf", ovf_a, 4'b1000);
        ack = 1'b1; ack_id = 2'd3;
        cyc();
        ack = 1'b0;
        chk("ovf_ack_ext", ext_a, 4'b0000);
        chk("ovf_ack_ovf", ovf_a, 4'b1000);
        clear = 4'b1000;
        cyc();
        clear = '0;
        chk("ovf_clr_ovf", ovf_a, 4'b0000);

        // ---- simultaneous rise with ack, then with clear, line 0 ----
        do_reset();
        edge_mode = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            irq_raw = (n <= 2 || n == 5 || n == 6 || n >= 9) ? 4'b0001 : 4'b0000;
            ack     = (n == 7);
            ack_id  = 2'd0;
            clear   = (n == 11) ? 4'b0001 : 4'b0000;
            cyc();
            if (n == 7) begin
                chk("sim_ack_ext", ext_a, 4'b0001);
                chk("sim_ack_ovf", ovf_a, 4'b0000);
            end
            if (n == 11) begin
                chk("sim_clr_ext", ext_a, 4'b0001);
                chk("sim_clr_ovf", ovf_a, 4'b0000);
            end
        end
        ack = 1'b0; clear = '0;

        // ---- reset with lines pending and all inputs high ----
        edge_mode = 4'b1111;
        irq_raw   = 4'b1111;
        repeat (8) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_mid_ext_d1", ext_a, 4'b0000);
        chk("rst_mid_ovf_d1", ovf_a, 4'b0000);
        chk("rst_mid_ext_d4", ext_b, 4'b0000);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            if (n == 2) chk("rel_edge2", ext_a, 4'b0000);
            if (n == 3) chk("rel_edge3", ext_a, 4'b1111);
            if (n == 5) chk("rel_d4_edge5", ext_b, 4'b0000);
            if (n == 6) chk("rel_d4_edge6", ext_b, 4'b1111);
        end
        chk("rel_no_ovf_d1", ovf_a, 4'b0000);
        chk("rel_no_ovf_d4", ovf_b, 4'b0000);

        // ---- randomized traffic against the model ----
        do_reset();
        edge_mode = 4'($urandom);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) irq_raw[i] = ~irq_raw[i];
            if ($urandom_range(99) == 0) edge_mode = 4'($urandom);
            ack    = ($urandom_range(4) == 0);
            ack_id = 2'($urandom);
            clear  = ($urandom_range(19) == 0) ? 4'($urandom) : 4'b0000;
            reset  = ($urandom_range(399) == 0);
            cyc();
        end
        reset = 1'b0; ack = 1'b0; clear = '0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
